logic_op_pipe: RTL and testbench

//   Parametrised, pipelined bitwise logic unit for the CPU datapath. It

---
 rtl/logic_op_pipe.sv | 102 ++++++++++
 tb/tb_logic_op_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// Bitwise logic unit (AND/OR/XOR/NOR) feeding an elastic valid/ready pipeline.
// Each stage carries {valid, result, zero}. Backpressure ripples combinationally, so there is no bubble.
module logic_op_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  logic [WIDTH-1:0] res_d;
  logic             zero_d;

  always_comb begin
    res_d = '0;
    case (op)
      OP_AND:  res_d = in1 & in2;
      OP_OR:   res_d = in1 | in2;
      OP_XOR:  res_d = in1 ^ in2;
      OP_NOR:  res_d = ~(in1 | in2);
      default: res_d = '0;
    endcase
    zero_d = ~|res_d;
  end

  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] z_vec;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  r_arr [STAGES];

  // A stage may load when it, or any stage downstream of it, has a free slot,
  // or when the consumer is taking the output this cycle.
  always_comb begin : ld_chain
    logic hole;
    hole = out_ready;
    ld   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole  = hole | ~v_vec[k];
      ld[k] = hole;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q;
    logic             z_q;
    logic [WIDTH-1:0] r_q;
    logic             src_v;
    logic             src_z;
    logic [WIDTH-1:0] src_r;

    if (k == 0) begin : g_head
      assign src_v = in_valid;
      assign src_z = zero_d;
      assign src_r = res_d;
    end else begin : g_body
      assign src_v = v_vec[k-1];
      assign src_z = z_vec[k-1];
      assign src_r = r_arr[k-1];
    end

    // Data only moves with a valid beat, so the output holds its last value when idle.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        if (k == STAGES - 1) begin
          r_q <= '0;
          z_q <= 1'b0;
        end
      end else if (ld[k]) begin
        v_q <= src_v;
        if (src_v) begin
          r_q <= src_r;
          z_q <= src_z;
        end
      end
    end

    assign v_vec[k] = v_q;
    assign z_vec[k] = z_q;
    assign r_arr[k] = r_q;
  end

  assign in_ready  = ld[0];
  assign out_valid = v_vec[STAGES-1];
  assign out       = r_arr[STAGES-1];
  assign zero      = z_vec[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: a 32-bit/2-stage main instance plus 8-bit instances with 1 and 4 stages.
// A negedge monitor compares each emitted beat of the main instance against a queue of hand-computed results.
module tb_logic_op_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0]  op;
  logic [31:0] in1, in2, out;

  logic       s_in_valid, s_out_ready;
  logic [1:0] s_op;
  logic [7:0] s_in1, s_in2;
  logic       s1_in_ready, s1_out_valid, s1_zero;
  logic       s4_in_ready, s4_out_valid, s4_zero;
  logic [7:0] s1_out, s4_out;

  logic_op_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero));

  logic_op_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s1_in_ready), .op(s_op),
    .in1(s_in1), .in2(s_in2), .out_valid(s1_out_valid), .out_ready(s_out_ready),
    .out(s1_out), .zero(s1_zero));

  logic_op_pipe #(.WIDTH(8), .STAGES(4)) dut_s4 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s4_in_ready), .op(s_op),
    .in1(s_in1), .in2(s_in2), .out_valid(s4_out_valid), .out_ready(s_out_ready),
    .out(s4_out), .zero(s4_zero));

  int n_chk  = 0;
  int n_fail = 0;
  int n_emit = 0;
  logic [32:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
  endtask

  task automatic drain(input string tag, input int want_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    chk(tag, 64'(c), 64'(want_cyc));
  endtask

  // Transfer happens at the next rising edge; out_ready is stable from posedge+1 onward.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_emit++;
      if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
      else chk("beat", {31'd0, zero, out}, {31'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [32:0] t2_exp [4];
  int base;

  initial begin
    t2_exp[0] = 33'h0_A5A5_0000;
    t2_exp[1] = 33'h0_FFFF_A5A5;
    t2_exp[2] = 33'h0_5A5A_A5A5;
    t2_exp[3] = 33'h0_0000_5A5A;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; in1 = '0; in2 = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = 2'b00; s_in1 = '0; s_in2 = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_s1_valid", s1_out_valid, 0);
    chk("rst_s4_valid", s4_out_valid, 0);
    reset = 1'b0;

    // OR with two-cycle latency
    drive(2'b01, 32'hF0F0_0000, 32'h0F0F_0000);
    #1 chk("t1_in_ready", in_ready, 1);
    exp_q.push_back(33'h0_FFFF_0000);
    tick();
    in_valid = 1'b0;
    chk("t1_lat_n", out_valid, 0);
    tick();
    chk("t1_lat_n1", out_valid, 1);
    chk("t1_out", out, 32'hFFFF_0000);
    chk("t1_zero", zero, 0);
    tick();
    chk("t1_done", out_valid, 0);

    // All four ops back to back
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 32'hA5A5_A5A5, 32'hFFFF_0000);
      #1 chk("t2_in_ready", in_ready, 1);
      exp_q.push_back(t2_exp[i]);
      tick();
    end
    in_valid = 1'b0;
    drain("t2_drain", 2);

    // Zero flag from AND and NOR
    drive(2'b00, 32'h1234_5678, 32'h0000_0000);
    exp_q.push_back(33'h1_0000_0000);
    tick();
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back(33'h1_0000_0000);
    tick();
    in_valid = 1'b0;
    drain("t3_drain", 2);

    // Backpressure: only two of four offered beats fit
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(2'b10, 32'h0000_00FF, 32'h0000_0F0F);
        1: drive(2'b00, 32'hFFFF_FFFF, 32'h8000_0001);
        2: drive(2'b01, 32'h1111_1111, 32'h2222_2222);
        default: drive(2'b01, 32'h4444_4444, 32'h8888_8888);
      endcase
      #1 chk("t4_in_ready", in_ready, (i < 2) ? 64'd1 : 64'd0);
      if (i == 0) exp_q.push_back(33'h0_0000_0FF0);
      if (i == 1) exp_q.push_back(33'h0_8000_0001);
      tick();
      if (i >= 1) begin
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_out", out, 32'h0000_0FF0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t4_hold_out2", out, 32'h0000_0FF0);
    out_ready = 1'b1;
    drain("t4_drain", 2);

    // Full pipe with simultaneous accept and emit
    out_ready = 1'b0;
    drive(2'b01, 32'h0000_0001, 32'h0000_0100);
    exp_q.push_back(33'h0_0000_0101);
    tick();
    drive(2'b10, 32'hC000_0000, 32'h4000_0000);
    exp_q.push_back(33'h0_8000_0000);
    tick();
    out_ready = 1'b1;
    base = n_emit;
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 32'(i + 16), 32'(i + 16) << 8);
      #1 chk("t5_in_ready", in_ready, 1);
      chk("t5_out_valid", out_valid, 1);
      exp_q.push_back({1'b0, (32'(i + 16) << 8) | 32'(i + 16)});
      tick();
    end
    in_valid = 1'b0;
    chk("t5_emits", 64'(n_emit - base), 64'd10);
    drain("t5_drain", 2);

    // Reset with beats in flight and a beat offered during reset
    out_ready = 1'b0;
    drive(2'b01, 32'h0000_00AA, 32'h0000_5500);
    tick();
    drive(2'b01, 32'h0000_00BB, 32'h0000_6600);
    tick();
    reset = 1'b1;
    drive(2'b01, 32'h0000_00CC, 32'h0000_7700);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out", out, 0);
    chk("t6_zero", zero, 0);
    out_ready = 1'b1;
    base = n_emit;
    repeat (5) tick();
    chk("t6_no_emit", 64'(n_emit - base), 64'd0);

    // Latency of 1- and 4-stage 8-bit instances
    s_in_valid = 1'b1; s_op = 2'b01; s_in1 = 8'hF0; s_in2 = 8'h0C;
    #1 chk("t7_s1_ready", s1_in_ready, 1);
    chk("t7_s4_ready", s4_in_ready, 1);
    tick();
    s_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t7_s1_valid", s1_out_valid, (k == 0) ? 64'd1 : 64'd0);
      chk("t7_s4_valid", s4_out_valid, (k == 3) ? 64'd1 : 64'd0);
      if (k == 0) begin
        chk("t7_s1_out", s1_out, 8'hFC);
        chk("t7_s1_zero", s1_zero, 0);
      end
      if (k == 3) begin
        chk("t7_s4_out", s4_out, 8'hFC);
        chk("t7_s4_zero", s4_zero, 0);
      end
      tick();
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
